// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles a little-endian byte stream
// into 32-bit words, writes them to instruction memory from address 0 and
// holds the core in reset until the program is complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_wr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKS,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  cnt_lo;
  logic [15:0] cnt;
  logic [15:0] widx;
  logic [1:0]  lane;
  logic [15:0] hdr_n;
  logic        accept;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cks;
`endif

  assign accept    = in_valid & in_ready;
  assign hdr_n     = {in_byte, cnt_lo};
  assign mem_waddr = {14'd0, widx, 2'b00};

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_HDR0: if (accept) state_n = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_n = S_CKS;
`else
            state_n = S_DONE;
`endif
          end else if (32'(hdr_n) > DEPTH_WORDS) begin
            state_n = S_ERR;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: if (accept && lane == 2'd3) state_n = S_WRITE;
      S_WRITE: begin
        if (16'(widx + 16'd1) == cnt) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_n = S_CKS;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKS: if (accept) state_n = (in_byte == cks) ? S_DONE : S_ERR;
`endif
      S_DONE:  state_n = S_DONE;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_HDR0;
    endcase
  end

  // State register and outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_HDR0;
      in_ready  <= 1'b1;
      mem_wr    <= 1'b0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
`ifdef IMEM_LOADER_CKSUM_EN
      in_ready  <= (state_n == S_HDR0) || (state_n == S_HDR1) ||
                   (state_n == S_DATA) || (state_n == S_CKS);
`else
      in_ready  <= (state_n == S_HDR0) || (state_n == S_HDR1) ||
                   (state_n == S_DATA);
`endif
      mem_wr    <= (state_n == S_WRITE);
      core_hold <= (state_n != S_DONE);
      done      <= (state_n == S_DONE);
      err       <= (state_n == S_ERR);
    end
  end

  // Header capture, word assembly and word index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_lo    <= 8'd0;
      cnt       <= 16'd0;
      widx      <= 16'd0;
      lane      <= 2'd0;
      mem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      cks       <= 8'd0;
`endif
    end else begin
      if (accept && state == S_HDR0) cnt_lo <= in_byte;
      if (accept && state == S_HDR1) cnt <= hdr_n;
      if (accept && state == S_DATA) begin
        lane <= 2'(lane + 2'd1);
        // lane 0 starts a new word; previous word stays visible until then
        if (lane == 2'd0) mem_wdata <= {24'd0, in_byte};
        else              mem_wdata[{lane, 3'b000} +: 8] <= in_byte;
`ifdef IMEM_LOADER_CKSUM_EN
        cks <= cks ^ in_byte;
`endif
      end
      if (state == S_WRITE) widx <= 16'(widx + 16'd1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: header vector table plus scoreboarded program streams
// for imem_loader (build with or without IMEM_LOADER_CKSUM_EN).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_wr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [63:0] exp_q[$];
  logic [31:0] wq[$];

  imem_loader #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr, data}
  always @(negedge clk) begin
    if (reset && mem_wr) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_waddr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   mem_waddr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  function automatic int rgap(input int gap_max);
    if (gap_max <= 0) return 0;
    return int'($urandom_range(32'(gap_max), 0));
  endfunction

  // Sends header, all words in wq (expected writes pushed) and checksum
  task automatic send_prog(input int gap_max, input logic [7:0] cks_flip);
    logic [7:0]  c;
    logic [7:0]  b;
    logic [15:0] n;
    c = 8'd0;
    n = 16'(wq.size());
    send_byte(n[7:0], rgap(gap_max));
    send_byte(n[15:8], rgap(gap_max));
    for (int i = 0; i < wq.size(); i++) begin
      exp_q.push_back({32'(i * 4), wq[i]});
      for (int k = 0; k < 4; k++) begin
        b = wq[i][8*k +: 8];
        c = c ^ b;
        send_byte(b, rgap(gap_max));
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(c ^ cks_flip, rgap(gap_max));
`else
    if (cks_flip != 8'd0) c = c ^ cks_flip;
`endif
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [15:0] n;
    logic        e_done;
    logic        e_err;
    logic        e_rdy;
    logic        e_hold;
  } hvec_t;

  hvec_t tbl[5];

  initial begin
    int base;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    // Reset values (checked while reset is asserted)
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    // Header table: state one cycle after CNT_HI is accepted
`ifdef IMEM_LOADER_CKSUM_EN
    tbl[0] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    tbl[0] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    tbl[1] = '{16'h0101, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{16'h0100, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{16'h0001, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      send_byte(tbl[i].n[7:0], 0);
      send_byte(tbl[i].n[15:8], 0);
      chk("hdr_done", 32'(done), 32'(tbl[i].e_done));
      chk("hdr_err", 32'(err), 32'(tbl[i].e_err));
      chk("hdr_in_ready", 32'(in_ready), 32'(tbl[i].e_rdy));
      chk("hdr_core_hold", 32'(core_hold), 32'(tbl[i].e_hold));
    end
    chk("hdr_no_writes", 32'(wr_count), 32'd0);

    // Two-word program, back to back
    do_reset();
    wq = '{32'h00000013, 32'h00100093};
    send_prog(0, 8'h00);
`ifndef IMEM_LOADER_CKSUM_EN
    chk("last_write_strobe", 32'(mem_wr), 32'd1);
    chk("done_not_yet", 32'(done), 32'd0);
    chk("hold_not_yet", 32'(core_hold), 32'd1);
    @(negedge clk);
`endif
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_core_hold", 32'(core_hold), 32'd0);
    chk("prog_mem_wr_low", 32'(mem_wr), 32'd0);
    chk("prog_writes", 32'(wr_count), 32'd2);
    chk("prog_sb_empty", 32'(exp_q.size()), 32'd0);

    // Bytes offered after done are ignored
    base = wr_count;
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_done_ready", 32'(in_ready), 32'd0);
      chk("post_done_done", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
    chk("post_done_no_wr", 32'(wr_count), 32'(base));

    // Same program with random valid gaps
    do_reset();
    base = wr_count;
    send_prog(3, 8'h00);
    repeat (2) @(negedge clk);
    chk("gap_writes", 32'(wr_count - base), 32'd2);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-word discards the partial word
    do_reset();
    base = wr_count;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    #1;
    chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wq = '{32'hDDCCBBAA};
    send_prog(1, 8'h00);
    repeat (2) @(negedge clk);
    chk("midrst_writes", 32'(wr_count - base), 32'd1);
    chk("midrst_done", 32'(done), 32'd1);
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
    // Good checksum
    do_reset();
    wq = '{32'h08040201};
    send_prog(0, 8'h00);
    chk("cks_ok_done", 32'(done), 32'd1);
    chk("cks_ok_err", 32'(err), 32'd0);
    // Bad checksum (0x0E): word still written, err raised
    do_reset();
    base = wr_count;
    send_prog(0, 8'h01);
    chk("cks_bad_err", 32'(err), 32'd1);
    chk("cks_bad_hold", 32'(core_hold), 32'd1);
    chk("cks_bad_done", 32'(done), 32'd0);
    chk("cks_bad_written", 32'(wr_count - base), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the multicycle RISC-V datapath's 32-bit instruction memory. Receives a byte stream (header plus little-endian instruction words), assembles 32-bit words and writes them sequentially to instruction memory starting at byte address 0. Holds the core in reset until the program is fully written, then releases it so the PC starts fetching at 0.

## Interface
- `DEPTH_WORDS`, 256: instruction memory capacity in 32-bit words; larger counts are rejected.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  `in_byte` holds a valid byte.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_wr`  out  1  one-cycle write strobe to instruction memory.
- `mem_waddr`  out  32  byte address of the write, always word-aligned.
- `mem_wdata`  out  32  assembled instruction word.
- `core_hold`  out  1  active-high reset for the datapath; 1 while loading or in error.
- `done`  out  1  load completed successfully; sticky until reset.
- `err`  out  1  load rejected; sticky until reset.

## Operation
- Transfer happens when `in_valid & in_ready` is high at a rising edge. No other condition consumes a byte.
- Stream format: `CNT_LO`, `CNT_HI` form the 16-bit word count N. These are followed by N×4 data bytes, each word least-significant byte first. With checksum enabled, one checksum byte follows the data.
- States:
  - HDR0: accept `CNT_LO`, go to HDR1.
  - HDR1: accept `CNT_HI`, then:
    - N = 0 goes to DONE (or CKS if checksum enabled).
    - N > `DEPTH_WORDS` goes to ERR.
    - Otherwise go to DATA.
  - DATA: accept bytes into a 2-bit lane counter. The byte with lane k lands in bits [8k+7:8k]. After lane 3 is accepted, go to WRITE.
  - WRITE: `mem_wr` = 1 for exactly one cycle, `in_ready` = 0. Then increment the word index. If the index equals N, go to DONE (or CKS); otherwise go to DATA.
  - CKS (macro only): accept one byte. Match goes to DONE, mismatch goes to ERR.
  - DONE: `done` = 1, `core_hold` = 0, `in_ready` = 0. Further bytes are ignored.
  - ERR: `err` = 1, `core_hold` = 1, `in_ready` = 0. Further bytes are ignored.
- `mem_waddr` = word_index × 4. The word index is 16 bits wide and zero-extended to 32.
- `mem_wdata` is held stable from entry to WRITE until the next word's lane 0 is accepted.
- `in_ready` = 1 in HDR0, HDR1, DATA and CKS; 0 elsewhere.
- Reset while active, including mid-word or mid-header:
  - All state returns to HDR0 immediately (asynchronous).
  - Any partial word is discarded; no `mem_wr` is issued for it.
  - Memory contents already written are left untouched.

## Timing
- Reset values: state = HDR0, `in_ready` = 1, `mem_wr` = 0, `mem_waddr` = 0, `mem_wdata` = 0, `core_hold` = 1, `done` = 0, `err` = 0.
- Word write latency: `mem_wr` is high in the cycle after the edge that accepts lane 3.
- Maximum throughput: one word per 5 cycles (4 accept cycles plus 1 WRITE cycle).
- `done` rises, and `core_hold` falls, in the cycle after the final WRITE (or after the checksum byte is accepted). The memory write is therefore complete before the core leaves reset.
- `err` rises in the cycle after the offending byte is accepted.
- `in_valid` may toggle freely; bubbles stall the FSM without side effects.
- All outputs are registered; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `IMEM_LOADER_CKSUM_EN`:
  - Defined: a trailing checksum byte is required, equal to the XOR of all N×4 data bytes (0x00 when N = 0). The CKS state is present; a mismatch goes to ERR, but words already written remain in memory.
  - Undefined: there is no CKS state and no checksum byte; DONE follows the last WRITE directly (or HDR1 when N = 0).

## Test plan
- Reset then stream 02 00 13 00 00 00 93 00 10 00:
  - `mem_wr` pulses with (0x0, 0x00000013) and then (0x4, 0x00100093).
  - `done` = 1 and `core_hold` = 0 one cycle after the second pulse.
- Count 0x0101 with `DEPTH_WORDS` = 256 → `err` = 1 the cycle after `CNT_HI`, `in_ready` = 0, no `mem_wr`, `core_hold` stays 1.
- Insert random `in_valid` gaps into the 2-word stream → identical writes and addresses; `mem_wr` high for exactly 2 cycles in total.
- Assert `reset` = 0 after 2 data bytes, then release and send a fresh 1-word stream AA BB CC DD → single write of (0x0, 0xDDCCBBAA); the discarded partial word is never written.
- With `IMEM_LOADER_CKSUM_EN` defined, stream 01 00 01 02 04 08 then 0x0F → `done` = 1. With checksum 0x0E instead → `err` = 1, `core_hold` = 1, and the word at 0x0 is still written as 0x08040201.
- After `done`, drive `in_valid` = 1 for 10 cycles → `in_ready` = 0, no `mem_wr`, and `done` stays 1.
